pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Multi-channel PWM controller that owns the per-channel duty-cycle registers of the PWM generator and sequences duty changes safely. Software or upstream logic writes target duties through a valid/ready config port. The block ramps each channel's active duty toward its target in fixed steps, and applies changes only at period boundaries, so outputs never glitch mid-period. It sits between the system control logic and the PWM output pins.

## Interface
Parameters:
- CH, 8: number of PWM channels
- PERIOD, 100: PWM period in clk cycles (counter runs 0..PERIOD-1)
- STEP, 5: maximum duty change per period, in counts
- DW, 7: duty/counter width; must satisfy 2^DW > PERIOD
- CHW, 3: channel index width, $clog2(CH)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- enable  in  1  run PWM; low holds counter and forces outputs low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write can be accepted this cycle
- cfg_ch  in  CHW  target channel index; values >= CH are accepted and ignored
- cfg_duty  in  DW  target duty in counts; values > PERIOD are clamped to PERIOD
- pwm  out  CH  PWM outputs, registered
- period_start  out  1  one-cycle pulse marking the first cycle of each period
- busy  out  1  high while any channel's active duty differs from its target

## Operation
- Per channel i: tgt[i] holds the target duty and cur[i] holds the active duty, both DW bits.
- Period counter cnt runs 0..PERIOD-1 while enable=1, then wraps to 0. While enable=0, cnt is forced to 0 on the next edge.
- Config write occurs when cfg_valid && cfg_ready: tgt[cfg_ch] <= min(cfg_duty, PERIOD). Writes to the same channel on consecutive cycles: the last write wins.
- cfg_ready = 1 except:
  - during reset;
  - in the boundary cycle (enable && cnt==PERIOD-1).
- Boundary update: on the edge that ends the boundary cycle, each cur[i] moves toward tgt[i]:
  - if tgt > cur: cur <= cur + min(STEP, tgt-cur);
  - if tgt < cur: cur <= cur - min(STEP, cur-tgt);
  - the step never overshoots the target.
- cur[i] never changes outside a boundary edge. While enable=0, ramping is frozen and config writes are still accepted.
- PWM compare: pwm[i] is high for cnt < cur[i].
  - duty 0 gives constantly low.
  - duty PERIOD gives constantly high.
- FSM: IDLE and RAMP.
  - IDLE -> RAMP on the edge where any cur != tgt (evaluated on next-state values).
  - RAMP -> IDLE when all cur == tgt after a boundary edge.
  - busy = (state == RAMP).
- Reset (rst_n low at an edge): cnt=0, all cur=0, all tgt=0, state=IDLE, pwm=0, period_start=0, busy=0, cfg_ready=0. Reset mid-ramp abandons the ramp; there is no partial retention.

## Timing
- All outputs are registered.
- pwm[i](t+1) = enable(t) && (cnt(t) < cur[i](t)).
- period_start(t+1) = enable(t) && cnt(t)==0.
- Period-boundary update: a new cur value takes effect for cnt=0 of the next period, which is seen on pwm one cycle later, aligned with period_start.
- Config write latency: tgt updates the edge after acceptance. The first visible duty change is at the next period_start after the following boundary edge. A write accepted in cnt==PERIOD-2 affects the immediately following period.
- busy latency: rises 1 cycle after the accepting edge. Falls 1 cycle after the final boundary edge.
- cfg_ready: drops combinationally-registered so that it is low exactly in the boundary cycle. It is high again at cnt==0.
- Ramp length: from a to b takes ceil(|b-a|/STEP) periods.
- Disable at cnt=k: cnt=0 and pwm=0 from the next cycle; cur/tgt are held. Re-enable restarts at cnt=0 with period_start.
- First cycle after rst_n rises: cfg_ready=1 and cnt begins counting if enable=1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with cfg_valid=1 -> pwm=0, busy=0, cfg_ready=0, no write taken. After release, cfg_ready=1 next cycle.
- Ramp up: enable=1, write ch0=20 -> busy=1; pwm[0] high-time per period is 5, 10, 15, 20, then 20 steady; busy falls after the 4th boundary; other channels stay 0.
- Clamp: write ch3=120 -> tgt=100; after 20 periods, pwm[3] is constant high across the wrap; write ch9 (CHW=4 build) or an out-of-range index -> no state change.
- Ramp down with non-multiple: ch0 at 20, write 3 -> high-times 15, 10, 5, 3, then busy=0.
- Handshake stall: assert cfg_valid in cycle cnt==99 -> cfg_ready=0 that cycle, write accepted at cnt==0. Back-to-back writes ch1=40 then ch1=10 -> ramp targets 10.
- Disable mid-period: enable low at cnt=40 during ramp -> next cycle pwm=0, cnt=0, cur frozen. Re-enable after 7 cycles -> period_start pulse, ramp resumes from the frozen value.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - multi-channel PWM with period-aligned, step-limited duty ramping
module pwm_ramp_ctrl #(
  parameter int CH     = 8,
  parameter int PERIOD = 100,
  parameter int STEP   = 5,
  parameter int DW     = 7,
  parameter int CHW    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [DW-1:0]  cfg_duty,
  output logic [CH-1:0]  pwm,
  output logic           period_start,
  output logic           busy
);

  localparam logic [DW-1:0] PER_D  = DW'(PERIOD);
  localparam logic [DW-1:0] LAST_D = DW'(PERIOD - 1);
  localparam logic [DW-1:0] STEP_D = DW'(STEP);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state, state_n;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cur   [CH];
  logic [DW-1:0] tgt   [CH];
  logic [DW-1:0] cur_n [CH];
  logic [DW-1:0] tgt_n [CH];
  logic          alive;
  logic          boundary;
  logic          wr;
  logic          any_diff_n;
  logic [DW-1:0] duty_clamped;

  // The boundary cycle blocks writes so a target never changes under the ramp step.
  assign boundary     = enable && (cnt == LAST_D);
  assign cfg_ready    = alive && !boundary;
  assign wr           = cfg_valid && cfg_ready;
  assign duty_clamped = (cfg_duty > PER_D) ? PER_D : cfg_duty;
  assign busy         = (state == RAMP);

  always_comb begin
    any_diff_n = 1'b0;
    for (int i = 0; i < CH; i++) begin
      tgt_n[i] = tgt[i];
      cur_n[i] = cur[i];
      if (wr && (cfg_ch == CHW'(i)))
        tgt_n[i] = duty_clamped;
      if (boundary) begin
        if (tgt[i] > cur[i])
          cur_n[i] = ((tgt[i] - cur[i]) > STEP_D) ? cur[i] + STEP_D : tgt[i];
        else if (tgt[i] < cur[i])
          cur_n[i] = ((cur[i] - tgt[i]) > STEP_D) ? cur[i] - STEP_D : tgt[i];
      end
      if (cur_n[i] != tgt_n[i])
        any_diff_n = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_diff_n) state_n = RAMP;
      RAMP:    if (boundary && !any_diff_n) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      state        <= IDLE;
      pwm          <= '0;
      period_start <= 1'b0;
      alive        <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      alive        <= 1'b1;
      state        <= state_n;
      period_start <= enable && (cnt == '0);
      if (!enable || (cnt == LAST_D))
        cnt <= '0;
      else
        cnt <= cnt + DW'(1);
      for (int i = 0; i < CH; i++) begin
        pwm[i] <= enable && (cnt < cur[i]);
        cur[i] <= cur_n[i];
        tgt[i] <= tgt_n[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed, table-driven bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  localparam int CH     = 8;
  localparam int PERIOD = 100;
  localparam int NV     = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_ch;
  logic [6:0]    cfg_duty;
  logic [CH-1:0] pwm;
  logic          period_start;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int ht     [CH];
  int lowcnt [CH];
  int model  [CH];

  typedef struct packed {
    logic [3:0]      ch;
    logic [6:0]      duty;
    logic            busy0;
    logic [4:0][7:0] ht;
    logic [4:0]      bz;
  } vec_t;

  vec_t vecs [NV];

  pwm_ramp_ctrl #(.CH(CH), .PERIOD(PERIOD), .STEP(5), .DW(7), .CHW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_duty     (cfg_duty),
    .pwm          (pwm),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Measures one full period of high-times, starting at the next period_start.
  task automatic measure();
    int guard = 0;
    while (!period_start && guard < 3 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout: got no period_start expected one within %0d cycles", 3 * PERIOD);
    end
    for (int c = 0; c < CH; c++) begin
      ht[c]     = 0;
      lowcnt[c] = 0;
    end
    for (int k = 0; k < PERIOD; k++) begin
      for (int c = 0; c < CH; c++) begin
        if (pwm[c]) ht[c]++;
        else        lowcnt[c]++;
      end
      @(negedge clk);
    end
  endtask

  task automatic write(input int ch, input int duty);
    int guard = 0;
    cfg_ch    = 4'(ch);
    cfg_duty  = 7'(duty);
    cfg_valid = 1'b1;
    while (!cfg_ready && guard < 3 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got cfg_ready 0 expected 1 within %0d cycles", 3 * PERIOD);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_others(input string name, input int skip);
    int bad = 0;
    for (int c = 0; c < CH; c++)
      if (c != skip && ht[c] != model[c]) bad++;
    check(name, bad, 0);
  endtask

  initial begin
    int lows;
    rst_n     = 1'b0;
    enable    = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 4'd0;
    cfg_duty  = 7'd50;
    for (int c = 0; c < CH; c++) model[c] = 0;

    vecs[0] = '{ch: 4'd0, duty: 7'd20, busy0: 1'b1,
                ht: {8'd20, 8'd20, 8'd15, 8'd10, 8'd5},  bz: 5'b00011};
    vecs[1] = '{ch: 4'd0, duty: 7'd3,  busy0: 1'b1,
                ht: {8'd3,  8'd3,  8'd5,  8'd10, 8'd15}, bz: 5'b00011};
    vecs[2] = '{ch: 4'd5, duty: 7'd7,  busy0: 1'b1,
                ht: {8'd7,  8'd7,  8'd7,  8'd7,  8'd5},  bz: 5'b00000};
    vecs[3] = '{ch: 4'd7, duty: 7'd0,  busy0: 1'b0,
                ht: {8'd0,  8'd0,  8'd0,  8'd0,  8'd0},  bz: 5'b00000};
    vecs[4] = '{ch: 4'd2, duty: 7'd12, busy0: 1'b1,
                ht: {8'd12, 8'd12, 8'd12, 8'd10, 8'd5},  bz: 5'b00001};

    // Reset held with a pending write
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check($sformatf("rst%0d_pwm", r), int'(pwm), 0);
      check($sformatf("rst%0d_busy", r), int'(busy), 0);
      check($sformatf("rst%0d_ready", r), int'(cfg_ready), 0);
    end
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(cfg_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_pstart", int'(period_start), 1);
    measure();
    check_others("post_rst_all_zero", -1);

    for (int v = 0; v < NV; v++) begin
      write(int'(vecs[v].ch), int'(vecs[v].duty));
      check($sformatf("v%0d_busy0", v), int'(busy), int'(vecs[v].busy0));
      for (int k = 0; k < 5; k++) begin
        measure();
        check($sformatf("v%0d_p%0d_ht", v, k), ht[vecs[v].ch], int'(vecs[v].ht[k]));
        check_others($sformatf("v%0d_p%0d_others", v, k), int'(vecs[v].ch));
        check($sformatf("v%0d_p%0d_busy", v, k), int'(busy), int'(vecs[v].bz[k]));
      end
      model[vecs[v].ch] = int'(vecs[v].duty);
    end

    // Out-of-range channel index is ignored
    write(9, 50);
    check("oor_busy", int'(busy), 0);
    measure();
    check_others("oor_unchanged", -1);

    // Clamp 120 -> 100, ramp of 20 periods, then constant high across the wrap
    write(3, 120);
    check("clamp_busy0", int'(busy), 1);
    for (int k = 1; k <= 20; k++) begin
      measure();
      check($sformatf("clamp_p%0d_ht", k), ht[3], 5 * k);
    end
    check("clamp_busy_done", int'(busy), 0);
    model[3] = 100;
    lows = 0;
    for (int k = 0; k < 2; k++) begin
      measure();
      check($sformatf("clamp_full_%0d", k), ht[3], PERIOD);
      lows += lowcnt[3];
    end
    check("clamp_no_low", lows, 0);
    check_others("clamp_others", 3);

    // Handshake stall at cnt==99, then back-to-back writes to ch1
    repeat (98) @(negedge clk);
    cfg_ch    = 4'd1;
    cfg_duty  = 7'd40;
    cfg_valid = 1'b1;
    check("stall_ready_low", int'(cfg_ready), 0);
    @(negedge clk);
    check("stall_ready_high", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_duty = 7'd10;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("b2b_busy", int'(busy), 1);
    measure();
    check("b2b_p0_ht", ht[1], 5);
    measure();
    check("b2b_p1_ht", ht[1], 10);
    measure();
    check("b2b_p2_ht", ht[1], 10);
    check("b2b_busy_done", int'(busy), 0);
    model[1] = 10;

    // Disable mid-period during a ramp of ch0 3 -> 23
    write(0, 23);
    measure();
    check("dis_pre_ht", ht[0], 8);
    repeat (39) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_pwm", int'(pwm), 0);
    check("dis_pstart", int'(period_start), 0);
    check("dis_busy", int'(busy), 1);
    lows = 0;
    repeat (7) begin
      @(negedge clk);
      if (pwm != '0 || period_start) lows++;
    end
    check("dis_hold_quiet", lows, 0);
    check("dis_ready", int'(cfg_ready), 1);
    enable = 1'b1;
    @(negedge clk);
    check("reen_pstart", int'(period_start), 1);
    measure();
    check("reen_p0_ht", ht[0], 13);
    check_others("reen_p0_others", 0);
    check("reen_p0_busy", int'(busy), 1);
    measure();
    check("reen_p1_ht", ht[0], 18);
    check("reen_p1_busy", int'(busy), 0);
    measure();
    check("reen_p2_ht", ht[0], 23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
